// File: rtl/aes_sub_bytes_seq.sv
// aes_sub_bytes_seq: forward AES SubBytes over a 128-bit state, BYTES_PER_CYCLE bytes per clock
module aes_sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);
  localparam int NCH = 16 / BYTES_PER_CYCLE;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [127:0]  data_q, data_d;
  logic          accept;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  assign in_ready  = state_q == IDLE || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_block = out_valid ? data_q : '0;
  // Substitute the current chunk in place; the chunk mux feeds BYTES_PER_CYCLE shared S-boxes.
  always_comb begin
    data_d = data_q;
    for (int j = 0; j < BYTES_PER_CYCLE; j++)
      data_d[(int'(cnt_q) * BYTES_PER_CYCLE + j) * 8 +: 8] = sbox(data_q[(int'(cnt_q) * BYTES_PER_CYCLE + j) * 8 +: 8]);
  end
  // Control FSM: capture on accept (also back-to-back from DONE), walk the chunks, hold in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
    end else if (accept) begin
      state_q <= BUSY;
      cnt_q   <= '0;
      data_q  <= in_block;
    end else if (state_q == BUSY) begin
      data_q  <= data_d;
      cnt_q   <= cnt_q == LAST ? '0 : cnt_q + CW'(1);
      state_q <= cnt_q == LAST ? DONE : BUSY;
    end else if (state_q == DONE && out_ready) begin
      state_q <= IDLE;
    end
  end
endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// tb_aes_sub_bytes_seq: vector, corner-case and randomized checks of aes_sub_bytes_seq
module tb_aes_sub_bytes_seq;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_block = '0;
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] out_block [3];
  int           n_cmp = 0, n_err = 0;
  logic [7:0]   sref [256];

  typedef struct {
    logic [127:0] blk;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [4];
  int   lat_exp [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]), .in_block(in_block),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out_block(out_block[0]), .busy(busy[0]));
  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]), .in_block(in_block),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out_block(out_block[1]), .busy(busy[1]));
  aes_sub_bytes_seq #(.BYTES_PER_CYCLE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]), .in_block(in_block),
    .out_valid(out_valid[2]), .out_ready(out_ready), .out_block(out_block[2]), .busy(busy[2]));

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S(x) = affine(x^-1), with 0 mapping to inverse 0
  function automatic logic [7:0] sbox_math(input int x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sref[blk[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int lat [3];
    logic [127:0] got [3];
    logic [127:0] a, b;
    logic [127:0] q [$];
    int t, seen, sent, rcvd, cyc;
    logic acc;
    for (int x = 0; x < 256; x++) sref[x] = sbox_math(x);
    vecs[0] = '{128'h0, {16{8'h63}}};
    vecs[1] = '{{96'h0, 32'hff530100}, {96'h636363636363636363636363, 32'h16ed7c63}};
    vecs[2] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[3] = '{{16{8'h53}}, {16{8'hed}}};

    // reset state, during and after reset
    repeat (3) @(negedge clk);
    check("rst_in_ready", 128'(in_ready[0]), 128'd1);
    check("rst_out_valid", 128'(out_valid[0]), 128'd0);
    check("rst_out_block", out_block[0], 128'h0);
    check("rst_busy", 128'(busy[0]), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 128'(in_ready[0]), 128'd1);
    check("idle_busy", 128'(busy[0]), 128'd0);

    // table vectors through all three widths at once
    foreach (vecs[v]) begin
      in_valid = 1'b1; in_block = vecs[v].blk; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_block = rnd128();
      lat = '{0, 0, 0};
      got = '{128'h0, 128'h0, 128'h0};
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        for (int d = 0; d < 3; d++)
          if (out_valid[d] && lat[d] == 0) begin lat[d] = c; got[d] = out_block[d]; end
      end
      for (int d = 0; d < 3; d++) begin
        check($sformatf("vec%0d_lat_dut%0d", v, d), 128'(lat[d]), 128'(lat_exp[d]));
        check($sformatf("vec%0d_data_dut%0d", v, d), got[d], vecs[v].exp);
      end
    end

    // backpressure in DONE with a pending block, then back-to-back accept
    a = rnd128(); b = rnd128();
    in_valid = 1'b1; in_block = a; out_ready = 1'b0;
    @(negedge clk);
    in_block = b;
    t = 0;
    while (!out_valid[0] && t < 50) begin @(negedge clk); t++; end
    check("bp_lat", 128'(t), 128'd4);
    for (int c = 0; c < 10; c++) begin
      check("bp_hold_block", out_block[0], ref_sub(a));
      check("bp_hold_ready", 128'(in_ready[0]), 128'd0);
      check("bp_hold_valid", 128'(out_valid[0]), 128'd1);
      @(negedge clk);
    end
    check("bp_busy_done", 128'(busy[0]), 128'd1);
    out_ready = 1'b1;
    #1 check("bp_ready_release", 128'(in_ready[0]), 128'd1);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 50) begin @(negedge clk); t++; end
    check("b2b_lat", 128'(t), 128'd4);
    check("b2b_data", out_block[0], ref_sub(b));

    // asynchronous reset two cycles after accept
    repeat (20) @(negedge clk);
    in_valid = 1'b1; in_block = rnd128(); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 128'(busy[0]), 128'd0);
    check("arst_in_ready", 128'(in_ready[0]), 128'd1);
    check("arst_out_valid", 128'(out_valid[0]), 128'd0);
    check("arst_out_block", out_block[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin @(negedge clk); if (out_valid[0]) seen++; end
    check("arst_no_output", 128'(seen), 128'd0);
    in_valid = 1'b1; in_block = {16{8'h53}};
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid[0] && t < 50) begin @(negedge clk); t++; end
    check("post_rst_lat", 128'(t), 128'd4);
    check("post_rst_data", out_block[0], {16{8'hed}});

    // randomized regression against the reference model
    repeat (20) @(negedge clk);
    sent = 0; rcvd = 0; cyc = 0; acc = 1'b0;
    while (rcvd < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
        in_valid = 1'b1; in_block = rnd128();
      end
      out_ready = $urandom_range(3) != 0;
      #1;
      if (out_valid[0] && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rand_unexpected: got %h expected no output", out_block[0]);
        end else check("rand_out", out_block[0], q.pop_front());
        rcvd++;
      end else if (!out_valid[0]) check("rand_idle_zero", out_block[0], 128'h0);
      if (in_valid && in_ready[0]) begin
        q.push_back(ref_sub(in_block));
        sent++;
        acc = 1'b1;
      end
    end
    check("rand_received", 128'(rcvd), 128'd1000);
    check("rand_leftover", 128'(q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
